apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
Round-robin scheduler that shares the single apb_master among NUM_REQ upstream requesters.
It accepts one request at a time and latches its fields. It drives the apb_master upstream port (transfer, WRITE_READ, addresses, write data) and detects completion by monitoring the APB bus. It then returns read data and the error flag to the granted requester.
It sits between the system-side clients and apb_master, one level above the APB bus.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, `ADDR_WIDTH, address width
DATA_W, `DATA_WIDTH, data width

Ports:
Pclk  in  1  clock
Presetn  in  1  reset; asynchronous, active-low
req_valid  in  NUM_REQ  per-requester request; held until req_ready
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
rsp_rdata  out  DATA_W  read data; valid with rsp_valid
rsp_slverr  out  1  slave error; valid with rsp_valid
transfer  out  1  to apb_master
WRITE_READ  out  1  to apb_master
APB_write_paddr  out  ADDR_W  to apb_master
APB_read_paddr  out  ADDR_W  to apb_master
APB_write_data  out  DATA_W  to apb_master
Psel  in  1  bus monitor
Penable  in  1  bus monitor
Pready  in  1  bus monitor
Prdata  in  DATA_W  bus monitor
Pslverr  in  1  bus monitor

Behaviour:
- Reset values: all outputs 0, state IDLE, rr pointer 0, latched fields 0. Reset mid-transaction aborts to IDLE; no rsp_valid is issued.
- All outputs are registered.
- States IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, pick a winner g by round-robin from pointer p: the first valid index scanning p, p+1, ..., wrapping modulo NUM_REQ.
  - Latch write/addr/wdata of g and assert req_ready[g] for one cycle.
  - Next state: ISSUE. Otherwise stay in IDLE.
- ISSUE:
  - transfer=1 for exactly one cycle.
  - WRITE_READ = latched write; both APB_write_paddr and APB_read_paddr = latched address; APB_write_data = latched wdata.
  - These values stay stable until the next grant.
  - Next state: WAIT.
- WAIT:
  - transfer=0.
  - On Psel & Penable & Pready in the same cycle: capture rdata = write ? 0 : Prdata, and slverr = Pslverr.
  - Next state: RESP. No timeout; a slave that never asserts Pready stalls the arbiter indefinitely.
- RESP:
  - rsp_valid[g]=1 for one cycle with rsp_rdata and rsp_slverr.
  - p <= (g+1) mod NUM_REQ.
  - Next state: IDLE.
- Latency: req_ready comes 1 cycle after req_valid is seen in IDLE. rsp_valid comes 2 cycles after the completing APB access cycle.
- Minimum request-to-request spacing: 5 cycles with a zero-wait-state slave.
- req_valid changes after acceptance are ignored; requests arriving during a transaction wait in IDLE arbitration.
- Simultaneous requests: exactly one grant per IDLE visit; the same requester cannot win twice in a row while others are valid.
- Pslverr completes the transaction like Pready; it does not retry.
- Bus activity seen outside WAIT is ignored.

Optional Feature:
- Macro APB_ARB_PRIO0_EN.
- Defined: requester 0 wins whenever req_valid[0]=1, regardless of p. The remaining requesters use round-robin. p updates only on non-zero grants.
- Undefined: pure round-robin across all requesters.

Decomposition:
- apb_pkg gains:
  - typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}
  - localparam ARB_NUM_REQ_DEF = 4
- Sub-module apb_rr_pick: purely combinational; inputs are the request vector and pointer; outputs are a one-hot grant and a binary index. It is reused for the optional priority path.

Test Plan:
1. Single read: req_valid=4'b0010, addr 0x10, slave returns 0xDEADBEEF with 2 wait states -> req_ready=4'b0010, one transfer pulse, rsp_valid=4'b0010, rsp_rdata=0xDEADBEEF, rsp_slverr=0.
2. All four request writes at once (addr 0x0/0x4/0x8/0xC), zero-wait slave -> grant order 0,1,2,3; four transfer pulses; rsp_rdata=0 on each write response.
3. Fairness: req 1 and 3 continuously valid after a grant to 1 -> grants alternate 3,1,3,1; p wraps from 3 to 0.
4. Error: read addr 0x20, slave asserts Pslverr with Pready -> rsp_slverr=1, next request is still serviced.
5. Presetn low during WAIT -> all outputs 0 next cycle, no rsp_valid; after release, pending req_valid[2] is granted first (p=0, only req 2 valid).
6. APB_ARB_PRIO0_EN defined, req 0 and 2 both held valid -> req 0 granted every time; undefined -> alternate 0,2.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB request arbiter.
// ADDR_WIDTH / DATA_WIDTH default to 32 when the build does not define them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package apb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  localparam int ARB_NUM_REQ_DEF = 4;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... modulo N.
module apb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] j;

  // scan from the pointer, wrapping, and keep the first hit
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin scheduler sharing one apb_master among NUM_REQ requesters.
// Optional APB_ARB_PRIO0_EN: requester 0 has absolute priority over the round-robin.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEF,
  parameter int ADDR_W  = `ADDR_WIDTH,
  parameter int DATA_W  = `DATA_WIDTH
) (
  input  logic                      Pclk,
  input  logic                      Presetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      transfer,
  output logic                      WRITE_READ,
  output logic [ADDR_W-1:0]         APB_write_paddr,
  output logic [ADDR_W-1:0]         APB_read_paddr,
  output logic [DATA_W-1:0]         APB_write_data,
  input  logic                      Psel,
  input  logic                      Penable,
  input  logic                      Pready,
  input  logic [DATA_W-1:0]         Prdata,
  input  logic                      Pslverr
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e         state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      g_idx;
  logic [NUM_REQ-1:0] g_grant;
  logic               lat_write;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [DATA_W-1:0]  cap_rdata;
  logic               cap_slverr;

  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] rr_grant;
  logic [IW-1:0]      rr_idx;
  logic [NUM_REQ-1:0] sel_grant;
  logic [IW-1:0]      sel_idx;

`ifdef APB_ARB_PRIO0_EN
  // requester 0 is handled outside the rotation
  assign pick_req = req_valid & ~{{(NUM_REQ-1){1'b0}}, 1'b1};
`else
  assign pick_req = req_valid;
`endif

  apb_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (pick_req),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // final grant selection
  always_comb begin
`ifdef APB_ARB_PRIO0_EN
    if (req_valid[0]) begin
      sel_grant = {{(NUM_REQ-1){1'b0}}, 1'b1};
      sel_idx   = '0;
    end else begin
      sel_grant = rr_grant;
      sel_idx   = rr_idx;
    end
`else
    sel_grant = rr_grant;
    sel_idx   = rr_idx;
`endif
  end

  // arbiter FSM with registered outputs
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state           <= ARB_IDLE;
      ptr             <= '0;
      g_idx           <= '0;
      g_grant         <= '0;
      lat_write       <= 1'b0;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      cap_rdata       <= '0;
      cap_slverr      <= 1'b0;
      req_ready       <= '0;
      rsp_valid       <= '0;
      rsp_rdata       <= '0;
      rsp_slverr      <= 1'b0;
      transfer        <= 1'b0;
      WRITE_READ      <= 1'b0;
      APB_write_paddr <= '0;
      APB_read_paddr  <= '0;
      APB_write_data  <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      transfer  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (|req_valid) begin
            req_ready <= sel_grant;
            g_grant   <= sel_grant;
            g_idx     <= sel_idx;
            lat_write <= req_write[sel_idx];
            lat_addr  <= req_addr[sel_idx*ADDR_W +: ADDR_W];
            lat_wdata <= req_wdata[sel_idx*DATA_W +: DATA_W];
            state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          transfer        <= 1'b1;
          WRITE_READ      <= lat_write;
          APB_write_paddr <= lat_addr;
          APB_read_paddr  <= lat_addr;
          APB_write_data  <= lat_wdata;
          state           <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (Psel && Penable && Pready) begin
            cap_rdata  <= lat_write ? '0 : Prdata;
            cap_slverr <= Pslverr;
            state      <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          rsp_valid  <= g_grant;
          rsp_rdata  <= cap_rdata;
          rsp_slverr <= cap_slverr;
`ifdef APB_ARB_PRIO0_EN
          if (g_idx != '0) ptr <= IW'(rr_next(int'(g_idx), NUM_REQ));
`else
          ptr <= IW'(rr_next(int'(g_idx), NUM_REQ));
`endif
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed table, reset-in-WAIT sequence,
// and randomized transactions checked against a round-robin reference model.
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef APB_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic            Pclk = 1'b0;
  logic            Presetn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_slverr;
  logic            transfer;
  logic            WRITE_READ;
  logic [AW-1:0]   APB_write_paddr;
  logic [AW-1:0]   APB_read_paddr;
  logic [DW-1:0]   APB_write_data;
  logic            Psel, Penable, Pready, Pslverr;
  logic [DW-1:0]   Prdata;

  logic            rq_write[N];
  logic [AW-1:0]   rq_addr[N];
  logic [DW-1:0]   rq_wdata[N];

  int nvec = 0;
  int nmis = 0;
  int mp   = 0;

  always #5 Pclk = ~Pclk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_write[i]              = rq_write[i];
      req_addr[i*AW +: AW]      = rq_addr[i];
      req_wdata[i*DW +: DW]     = rq_wdata[i];
    end
  end

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Pclk(Pclk), .Presetn(Presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .transfer(transfer), .WRITE_READ(WRITE_READ),
    .APB_write_paddr(APB_write_paddr), .APB_read_paddr(APB_read_paddr),
    .APB_write_data(APB_write_data),
    .Psel(Psel), .Penable(Penable), .Pready(Pready), .Prdata(Prdata), .Pslverr(Pslverr)
  );

  typedef struct {
    logic [3:0]  raise;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] step;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prd;
    logic        err;
    logic        hold;
    int          eg;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic [3:0] raise, input logic wr, input logic [31:0] addr,
                              input logic [31:0] step, input logic [31:0] wdata, input int waits,
                              input logic [31:0] prd, input logic err, input logic hold,
                              input int eg, input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.raise = raise; v.wr = wr; v.addr = addr; v.step = step; v.wdata = wdata;
    v.waits = waits; v.prd = prd; v.err = err; v.hold = hold;
    v.eg = eg; v.erd = erd; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: requester 0 first when prioritised, else first valid scanning from mp
  function automatic int model_pick(input logic [N-1:0] v);
    if (PRIO && v[0]) return 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mp + k) % N;
      if (!(PRIO && i == 0) && v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic any_out();
    return |{req_ready, rsp_valid, rsp_rdata, rsp_slverr, transfer, WRITE_READ,
             APB_write_paddr, APB_read_paddr, APB_write_data};
  endfunction

  task automatic clear_bus();
    Psel = 1'b0; Penable = 1'b0; Pready = 1'b0; Prdata = '0; Pslverr = 1'b0;
  endtask

  task automatic raise_reqs(input logic [3:0] m, input logic wr, input logic [31:0] addr,
                            input logic [31:0] step, input logic [31:0] wdata);
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        rq_write[i] = wr;
        rq_addr[i]  = addr + step * i;
        rq_wdata[i] = wdata + i;
        req_valid[i] = 1'b1;
      end
    end
  endtask

  // one full transaction: grant, issue, APB access with wait states, response
  task automatic do_txn(input int eg, input int waits, input logic [31:0] prd, input logic err,
                        input logic hold, input logic [31:0] erd, input logic eerr);
    int t;
    logic [3:0] exp_oh;
    exp_oh = 4'b0001 << eg;
    t = 0;
    do begin
      @(negedge Pclk);
      t++;
      if (req_ready == 4'b0) chk("quiet_rsp", rsp_valid, 0);
    end while (req_ready == 4'b0 && t < 30);
    if (req_ready == 4'b0) begin
      nvec++; nmis++;
      $display("FAIL grant_timeout: got no req_ready expected %0h", exp_oh);
      return;
    end
    chk("req_ready", req_ready, exp_oh);
    req_valid[eg] = hold;
    @(negedge Pclk);
    chk("transfer_hi", transfer, 1);
    chk("write_read", WRITE_READ, rq_write[eg]);
    chk("write_paddr", APB_write_paddr, rq_addr[eg]);
    chk("read_paddr", APB_read_paddr, rq_addr[eg]);
    chk("write_data", APB_write_data, rq_wdata[eg]);
    Psel = 1'b1; Penable = 1'b0; Pready = 1'b0; Prdata = ~prd; Pslverr = ~err;
    @(negedge Pclk);
    chk("transfer_pulse", transfer, 0);
    Penable = 1'b1;
    for (int w = 0; w < waits; w++) begin
      Pready = 1'b0;
      @(negedge Pclk);
      chk("rsp_early", rsp_valid, 0);
    end
    Pready = 1'b1; Prdata = prd; Pslverr = err;
    @(negedge Pclk);
    clear_bus();
    @(negedge Pclk);
    chk("rsp_valid", rsp_valid, exp_oh);
    chk("rsp_rdata", rsp_rdata, erd);
    chk("rsp_slverr", rsp_slverr, eerr);
    if (!PRIO || eg != 0) mp = (eg + 1) % N;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r;
    int          eg, waits, t;
    logic        wr, err, hold;
    logic [31:0] prd;

    for (int i = 0; i < N; i++) begin
      rq_write[i] = 1'b0; rq_addr[i] = '0; rq_wdata[i] = '0;
    end
    req_valid = '0;
    clear_bus();
    Presetn = 1'b0;

    // all four writes at once, then single read, fairness, error, two-requester contention
    tbl[0]  = mk(4'hF, 1'b1, 32'h0, 32'h4, 32'hA0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    tbl[1]  = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0,  0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 32'h0, 1'b0);
    tbl[2]  = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0,  0, 32'hFFFF_FFFF, 1'b0, 1'b0, 2, 32'h0, 1'b0);
    tbl[3]  = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0,  0, 32'hFFFF_FFFF, 1'b0, 1'b0, 3, 32'h0, 1'b0);
    tbl[4]  = mk(4'h2, 1'b0, 32'h10, 32'h0, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, 32'hDEAD_BEEF, 1'b0);
    tbl[5]  = mk(4'hA, 1'b0, 32'h30, 32'h0, 32'h0, 1, 32'h3000_0001, 1'b0, 1'b1, 3, 32'h3000_0001, 1'b0);
    tbl[6]  = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0,  0, 32'h3000_0002, 1'b0, 1'b1, 1, 32'h3000_0002, 1'b0);
    tbl[7]  = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0,  1, 32'h3000_0003, 1'b0, 1'b1, 3, 32'h3000_0003, 1'b0);
    tbl[8]  = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0,  0, 32'h3000_0004, 1'b0, 1'b0, 1, 32'h3000_0004, 1'b0);
    tbl[9]  = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0,  2, 32'h3000_0005, 1'b0, 1'b0, 3, 32'h3000_0005, 1'b0);
    tbl[10] = mk(4'h1, 1'b0, 32'h20, 32'h0, 32'h0, 1, 32'h0000_1234, 1'b1, 1'b0, 0, 32'h0000_1234, 1'b1);
    tbl[11] = mk(4'h4, 1'b0, 32'h24, 32'h0, 32'h0, 0, 32'hCAFE_0002, 1'b0, 1'b0, 2, 32'hCAFE_0002, 1'b0);
    tbl[12] = mk(4'h5, 1'b1, 32'h60, 32'h0, 32'h6000, 0, 32'h5555_AAAA, 1'b0, 1'b1, 0, 32'h0, 1'b0);
`ifdef APB_ARB_PRIO0_EN
    tbl[13] = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b1, 0, 32'h0, 1'b0);
    tbl[14] = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1, 32'h5555_AAAA, 1'b0, 1'b1, 0, 32'h0, 1'b0);
    tbl[15] = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    tbl[16] = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b0, 2, 32'h0, 1'b0);
`else
    tbl[13] = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b1, 2, 32'h0, 1'b0);
    tbl[14] = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1, 32'h5555_AAAA, 1'b0, 1'b1, 0, 32'h0, 1'b0);
    tbl[15] = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b0, 2, 32'h0, 1'b0);
    tbl[16] = mk(4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b0, 0, 32'h0, 1'b0);
`endif

    repeat (3) @(negedge Pclk);
    chk("reset_outputs", any_out(), 0);
    Presetn = 1'b1;
    mp = 0;

    for (int v = 0; v < NV; v++) begin
      raise_reqs(tbl[v].raise, tbl[v].wr, tbl[v].addr, tbl[v].step, tbl[v].wdata);
      do_txn(tbl[v].eg, tbl[v].waits, tbl[v].prd, tbl[v].err, tbl[v].hold, tbl[v].erd, tbl[v].eerr);
    end

    // reset while the arbiter is waiting on the slave
    raise_reqs(4'h2, 1'b0, 32'h40, 32'h0, 32'h0);
    t = 0;
    do begin
      @(negedge Pclk);
      t++;
    end while (req_ready == 4'b0 && t < 30);
    chk("rst_seq_ready", req_ready, 4'b0010);
    req_valid[1] = 1'b0;
    @(negedge Pclk);
    chk("rst_seq_transfer", transfer, 1);
    Psel = 1'b1;
    @(negedge Pclk);
    Penable = 1'b1;
    raise_reqs(4'h4, 1'b0, 32'h44, 32'h0, 32'h0);
    @(negedge Pclk);
    #2 Presetn = 1'b0;
    #1 chk("rst_async_outputs", any_out(), 0);
    @(negedge Pclk);
    chk("rst_held_outputs", any_out(), 0);
    clear_bus();
    @(negedge Pclk);
    Presetn = 1'b1;
    mp = 0;
    do_txn(2, 1, 32'h2222_0002, 1'b0, 1'b0, 32'h2222_0002, 1'b0);

    // randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      r = 4'($urandom_range(0, 15)) & ~req_valid;
      if ((req_valid | r) == 4'b0) r = 4'b0001 << $urandom_range(0, 3);
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          rq_write[i]  = 1'($urandom_range(0, 1));
          rq_addr[i]   = $urandom;
          rq_wdata[i]  = $urandom;
          req_valid[i] = 1'b1;
        end
      end
      eg    = model_pick(req_valid);
      waits = $urandom_range(0, 3);
      prd   = $urandom;
      err   = ($urandom_range(0, 3) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      wr    = rq_write[eg];
      do_txn(eg, waits, prd, err, hold, wr ? 32'h0 : prd, err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
